// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key gesture state enum and counter sizing helper
package key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } key_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// rtl/key_event_decoder_if.sv - key level in, gesture event pulses out
interface key_event_decoder_if;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic short_click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output key_level,
    input  press_pulse, release_pulse, short_click, double_click,
    input  long_press, repeat_pulse, held
  );

  modport slave (
    input  key_level,
    output press_pulse, release_pulse, short_click, double_click,
    output long_press, repeat_pulse, held
  );
endinterface

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - one-cycle delayed key level and rise/fall strobes
module key_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level_d <= 1'b0;
    else     r_level_d <= i_level;
  end

  assign o_rise = i_level & ~r_level_d;
  assign o_fall = ~i_level & r_level_d;

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - key gesture classifier; KEY_REPEAT_EN adds auto-repeat while held long
module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CYCLES    = 20_000_000,
  parameter int DBL_GAP_CYCLES = 10_000_000,
  parameter int REPEAT_CYCLES  = 5_000_000
) (
  input logic clk,
  input logic rst,
  key_event_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(max3(LONG_CYCLES, DBL_GAP_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);

  logic w_rise;
  logic w_fall;

  key_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .i_level (bus.key_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press, r_release, r_short, r_double, r_long, r_held;

`ifdef KEY_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES) + 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;
  logic             r_repeat;
`endif

  // Edge events take priority over the counter thresholds in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rpt     <= '0;
      r_repeat  <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
      if (r_state != IDLE && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        PRESSED, SECOND_PRESSED: begin
          if (w_fall) begin
            r_state   <= (r_state == PRESSED) ? WAIT_SECOND : IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_double  <= (r_state == SECOND_PRESSED);
            r_held    <= 1'b0;
          end else if (r_cnt == LONG_LAST) begin
            r_state <= LONG_HELD;
            r_cnt   <= '0;
            r_long  <= 1'b1;
`ifdef KEY_REPEAT_EN
            r_rpt   <= '0;
`endif
          end
        end
        LONG_HELD: begin
          if (w_fall) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_held    <= 1'b0;
          end
`ifdef KEY_REPEAT_EN
          else if (r_rpt == RPT_LAST) begin
            r_rpt    <= '0;
            r_repeat <= 1'b1;
          end else begin
            r_rpt <= r_rpt + 1'b1;
          end
`endif
        end
        WAIT_SECOND: begin
          if (w_rise) begin
            r_state <= SECOND_PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_held  <= 1'b1;
          end else if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_short <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_held  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press_pulse   = r_press;
  assign bus.release_pulse = r_release;
  assign bus.short_click   = r_short;
  assign bus.double_click  = r_double;
  assign bus.long_press    = r_long;
  assign bus.held          = r_held;
`ifdef KEY_REPEAT_EN
  assign bus.repeat_pulse  = r_repeat;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed gesture scenarios with hand-computed pulse cycles
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  int q_press[$], q_release[$], q_short[$], q_double[$], q_long[$], q_repeat[$];

  key_event_decoder_if bus ();

  key_event_decoder #(
    .LONG_CYCLES    (20),
    .DBL_GAP_CYCLES (8),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are logged with the index of the edge that produced them.
  always @(negedge clk) begin
    if (bus.press_pulse)   q_press.push_back(cyc);
    if (bus.release_pulse) q_release.push_back(cyc);
    if (bus.short_click)   q_short.push_back(cyc);
    if (bus.double_click)  q_double.push_back(cyc);
    if (bus.long_press)    q_long.push_back(cyc);
    if (bus.repeat_pulse)  q_repeat.push_back(cyc);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i, input int base);
    return (i < q.size()) ? q[i] - base : -1;
  endfunction

  task automatic clear_logs();
    q_press.delete();
    q_release.delete();
    q_short.delete();
    q_double.delete();
    q_long.delete();
    q_repeat.delete();
  endtask

  task automatic drive(input logic v, input int n);
    bus.key_level = v;
    repeat (n) @(negedge clk);
  endtask

  function automatic int outs();
    return {bus.press_pulse, bus.release_pulse, bus.short_click, bus.double_click,
            bus.long_press, bus.repeat_pulse, bus.held};
  endfunction

  int b;

  initial begin
    bus.key_level = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    drive(0, 3);

    // single click
    clear_logs(); b = cyc;
    drive(1, 3);
    check("s1_held_mid", int'(bus.held), 1);
    drive(1, 2);
    drive(0, 20);
    check("s1_press_at", at(q_press, 0, b), 1);
    check("s1_press_cnt", q_press.size(), 1);
    check("s1_release_at", at(q_release, 0, b), 6);
    check("s1_short_at", at(q_short, 0, b), 14);
    check("s1_short_cnt", q_short.size(), 1);
    check("s1_long_cnt", q_long.size(), 0);
    check("s1_double_cnt", q_double.size(), 0);
    check("s1_held_end", int'(bus.held), 0);

    // double click
    clear_logs(); b = cyc;
    drive(1, 3); drive(0, 4); drive(1, 3); drive(0, 20);
    check("s2_press_cnt", q_press.size(), 2);
    check("s2_press2_at", at(q_press, 1, b), 8);
    check("s2_release2_at", at(q_release, 1, b), 11);
    check("s2_double_at", at(q_double, 0, b), 11);
    check("s2_double_cnt", q_double.size(), 1);
    check("s2_short_cnt", q_short.size(), 0);

    // long hold
    clear_logs(); b = cyc;
    drive(1, 40); drive(0, 20);
    check("s3_long_at", at(q_long, 0, b), 21);
    check("s3_long_cnt", q_long.size(), 1);
    check("s3_release_at", at(q_release, 0, b), 41);
    check("s3_short_cnt", q_short.size(), 0);
    check("s3_double_cnt", q_double.size(), 0);
`ifdef KEY_REPEAT_EN
    check("s3_repeat_cnt", q_repeat.size(), 3);
    check("s3_repeat0_at", at(q_repeat, 0, b), 26);
    check("s3_repeat1_at", at(q_repeat, 1, b), 31);
    check("s3_repeat2_at", at(q_repeat, 2, b), 36);
`else
    check("s3_repeat_cnt", q_repeat.size(), 0);
`endif

    // fall on the long threshold, then rise on the gap timeout
    clear_logs(); b = cyc;
    drive(1, 20); drive(0, 8); drive(1, 3); drive(0, 20);
    check("s4_long_cnt", q_long.size(), 0);
    check("s4_release_at", at(q_release, 0, b), 21);
    check("s4_press2_at", at(q_press, 1, b), 29);
    check("s4_double_at", at(q_double, 0, b), 32);
    check("s4_short_cnt", q_short.size(), 0);

    // second press held long
    clear_logs(); b = cyc;
    drive(1, 3); drive(0, 4); drive(1, 25); drive(0, 20);
    check("s5_long_at", at(q_long, 0, b), 28);
    check("s5_long_cnt", q_long.size(), 1);
    check("s5_double_cnt", q_double.size(), 0);
    check("s5_short_cnt", q_short.size(), 0);
    check("s5_release2_at", at(q_release, 1, b), 33);

    // reset in WAIT_SECOND, release reset with key held
    drive(1, 3); drive(0, 3);
    clear_logs();
    rst = 1'b1;
    bus.key_level = 1'b1;
    repeat (2) @(negedge clk);
    check("s6_reset_outputs", outs(), 0);
    b = cyc;
    rst = 1'b0;
    drive(1, 12);
    check("s6_press_at", at(q_press, 0, b), 1);
    check("s6_press_cnt", q_press.size(), 1);
    check("s6_short_cnt", q_short.size(), 0);
    check("s6_held", int'(bus.held), 1);
    drive(0, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
